pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 151 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for a 5-stage in-order core.
// Detects load-use hazards between EX and ID, flushes on taken branches,
// and holds the front end while a multicycle multiply/divide runs, with
// a watchdog that forces release if the MDU never reports completion.
// All control outputs are Mealy: combinational from state and current inputs.
module pipe_hazard_ctrl #(
    parameter int MDU_TIMEOUT = 64,
    parameter int CNT_W       = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_use_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_memread,
    input  logic             branch_taken,
    input  logic             id_mdu_op,
    input  logic             mdu_done,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             idex_bubble,
    output logic             ifid_flush,
    output logic             mdu_start,
    output logic             mdu_timeout,
    output logic [1:0]       state_o,
    output logic [CNT_W-1:0] stall_cnt
);

    // Timer only needs to reach MDU_TIMEOUT-1; keep it at least one bit wide.
    localparam int TMR_W = (MDU_TIMEOUT > 1) ? $clog2(MDU_TIMEOUT) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(MDU_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    localparam logic [1:0] ST_RUN      = 2'b00;
    localparam logic [1:0] ST_LU_STALL = 2'b01;
    localparam logic [1:0] ST_MDU_BUSY = 2'b10;

    logic [1:0]       state_q, state_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             mdu_timeout_q, mdu_timeout_d;
    logic             load_use;

    // Load in EX writes a register the ID instruction actually reads (x0 never hazards).
    always_comb begin
        load_use = idex_memread && (idex_rd != 5'd0) &&
                   ((idex_rd == ifid_rs1) || (ifid_use_rs2 && (idex_rd == ifid_rs2)));
    end

    // Next-state, MDU timer/timeout and Mealy control outputs.
    always_comb begin
        state_d       = state_q;
        timer_d       = timer_q;
        mdu_timeout_d = mdu_timeout_q;
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        idex_bubble   = 1'b0;
        ifid_flush    = 1'b0;
        mdu_start     = 1'b0;

        case (state_q)
            ST_RUN: begin
                if (branch_taken) begin
                    // Wrong-path instructions in IF/ID and ID/EX are squashed;
                    // the PC still advances to the branch target.
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end else if (load_use) begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    state_d     = ST_LU_STALL;
                end else if (id_mdu_op) begin
                    mdu_start   = 1'b1;
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    timer_d     = '0;
                    state_d     = ST_MDU_BUSY;
                end
            end

            ST_LU_STALL: begin
                // The load has moved on to MEM, so the hazard is resolved by
                // forwarding; only a taken branch can alter this cycle.
                if (branch_taken) begin
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                state_d = ST_RUN;
            end

            ST_MDU_BUSY: begin
                // EX holds a bubble here, so branch_taken cannot be genuine.
                if (mdu_done) begin
                    state_d = ST_RUN;
                end else if (timer_q == TMR_LAST) begin
                    mdu_timeout_d = 1'b1;
                    state_d       = ST_RUN;
                end else begin
                    pc_write    = 1'b0;
                    ifid_write  = 1'b0;
                    idex_bubble = 1'b1;
                    timer_d     = timer_q + 1'b1;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Hold the front end and inject bubbles while reset is asserted.
        if (!rst_i) begin
            pc_write    = 1'b0;
            ifid_write  = 1'b0;
            idex_bubble = 1'b1;
            ifid_flush  = 1'b0;
            mdu_start   = 1'b0;
        end
    end

    // Frozen-PC cycle counter, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (!pc_write && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    // State registers; asynchronous reset abandons any MDU operation.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q       <= ST_RUN;
            timer_q       <= '0;
            stall_cnt_q   <= '0;
            mdu_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            timer_q       <= timer_d;
            stall_cnt_q   <= stall_cnt_d;
            mdu_timeout_q <= mdu_timeout_d;
        end
    end

    assign state_o     = state_q;
    assign stall_cnt   = stall_cnt_q;
    assign mdu_timeout = mdu_timeout_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process pushes the
// expected per-cycle response from a behavioural model; a monitor pops it.
module tb_pipe_hazard_ctrl;

    localparam int TMO   = 8;
    localparam int CW    = 6;
    localparam int CMAX  = (1 << CW) - 1;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic [4:0]    ifid_rs1 = '0, ifid_rs2 = '0, idex_rd = '0;
    logic          ifid_use_rs2 = 1'b0, idex_memread = 1'b0;
    logic          branch_taken = 1'b0, id_mdu_op = 1'b0, mdu_done = 1'b0;
    logic          pc_write, ifid_write, idex_bubble, ifid_flush, mdu_start;
    logic          mdu_timeout;
    logic [1:0]    state_o;
    logic [CW-1:0] stall_cnt;

    pipe_hazard_ctrl #(.MDU_TIMEOUT(TMO), .CNT_W(CW)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ifid_rs1(ifid_rs1), .ifid_rs2(ifid_rs2), .ifid_use_rs2(ifid_use_rs2),
        .idex_rd(idex_rd), .idex_memread(idex_memread),
        .branch_taken(branch_taken), .id_mdu_op(id_mdu_op), .mdu_done(mdu_done),
        .pc_write(pc_write), .ifid_write(ifid_write), .idex_bubble(idex_bubble),
        .ifid_flush(ifid_flush), .mdu_start(mdu_start),
        .mdu_timeout(mdu_timeout), .state_o(state_o), .stall_cnt(stall_cnt)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        bit pc, ifw, bub, fl, ms, to;
        int st;
        int cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    // Behavioural model: which phase the pipeline is in, how long the MDU
    // has been running, frozen-PC total and the sticky timeout flag.
    typedef enum int { P_RUN = 0, P_LOADWAIT = 1, P_MDU = 2 } phase_t;
    phase_t m_phase = P_RUN;
    int     m_busy_cycles = 0;
    int     m_frozen = 0;
    bit     m_to = 1'b0;

    task automatic chk(input string name, input int act, input int expv);
        n_checks++;
        if (act != expv) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step(input bit rst, input logic [4:0] rs1, input logic [4:0] rs2,
                        input bit use2, input logic [4:0] rd, input bit mr,
                        input bit br, input bit mop, input bit done);
        exp_t e;
        bit   hazard;
        @(negedge clk_i);
        rst_i = rst; ifid_rs1 = rs1; ifid_rs2 = rs2; ifid_use_rs2 = use2;
        idex_rd = rd; idex_memread = mr; branch_taken = br;
        id_mdu_op = mop; mdu_done = done;
        #1;
        hazard = mr && (rd != 0) && ((rd == rs1) || (use2 && rd == rs2));
        e.pc = 1; e.ifw = 1; e.bub = 0; e.fl = 0; e.ms = 0;
        if (!rst) begin
            e.pc = 0; e.ifw = 0; e.bub = 1; e.st = 0; e.cnt = 0; e.to = 0;
            m_phase = P_RUN; m_busy_cycles = 0; m_frozen = 0; m_to = 0;
        end else begin
            e.st = int'(m_phase); e.cnt = m_frozen; e.to = m_to;
            case (m_phase)
                P_RUN: begin
                    if (br) begin
                        e.fl = 1; e.bub = 1;
                    end else if (hazard) begin
                        e.pc = 0; e.ifw = 0; e.bub = 1; m_phase = P_LOADWAIT;
                    end else if (mop) begin
                        e.ms = 1; e.pc = 0; e.ifw = 0; e.bub = 1;
                        m_phase = P_MDU; m_busy_cycles = 0;
                    end
                end
                P_LOADWAIT: begin
                    if (br) begin e.fl = 1; e.bub = 1; end
                    m_phase = P_RUN;
                end
                default: begin
                    m_busy_cycles++;
                    if (done) m_phase = P_RUN;
                    else if (m_busy_cycles == TMO) begin m_to = 1; m_phase = P_RUN; end
                    else begin e.pc = 0; e.ifw = 0; e.bub = 1; end
                end
            endcase
            if (!e.pc && m_frozen < CMAX) m_frozen++;
        end
        sb.push_back(e);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle(1);
    endtask

    // Monitor: outputs are valid every cycle; compare mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk_i);
            #2;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("pc_write",    int'(pc_write),    int'(e.pc));
                chk("ifid_write",  int'(ifid_write),  int'(e.ifw));
                chk("idex_bubble", int'(idex_bubble), int'(e.bub));
                chk("ifid_flush",  int'(ifid_flush),  int'(e.fl));
                chk("mdu_start",   int'(mdu_start),   int'(e.ms));
                chk("mdu_timeout", int'(mdu_timeout), int'(e.to));
                chk("state_o",     int'(state_o),     e.st);
                chk("stall_cnt",   int'(stall_cnt),   e.cnt);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        #1 rst_i = 1'b0;
        do_reset();

        // Load-use on rs1, hazard inputs held through the stall cycle.
        step(1, 5, 0, 0, 5, 1, 0, 0, 0);
        step(1, 5, 0, 0, 5, 1, 0, 0, 0);
        #2;
        chk("lu_state", int'(state_o), 1);
        chk("lu_stall_cnt", int'(stall_cnt), 1);
        chk("lu_masked_pc", int'(pc_write), 1);
        idle(1);

        // No hazard through x0 or an unused rs2.
        step(1, 0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 3, 7, 0, 7, 1, 0, 0, 0);
        #2;
        chk("no_stall_rs2", int'(pc_write), 1);

        // Branch beats load-use and MDU op.
        step(1, 5, 0, 0, 5, 1, 1, 1, 0);
        #2;
        chk("br_flush", int'(ifid_flush), 1);
        chk("br_start", int'(mdu_start), 0);
        idle(1);
        chk("br_state", int'(state_o), 0);

        // MDU done on the 4th busy cycle.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(3);
        step(1, 0, 0, 0, 0, 0, 1, 0, 1);
        idle(1);
        #2;
        chk("mdu_done_cnt", int'(stall_cnt), 4);
        chk("mdu_done_state", int'(state_o), 0);

        // MDU timeout after 8 busy cycles, sticky.
        do_reset();
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(TMO);
        idle(3);
        #2;
        chk("timeout_sticky", int'(mdu_timeout), 1);
        chk("timeout_cnt", int'(stall_cnt), TMO);

        // Reset mid-MDU_BUSY.
        step(1, 0, 0, 0, 0, 0, 0, 1, 0);
        idle(2);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_state", int'(state_o), 0);
        chk("rst_cnt", int'(stall_cnt), 0);
        chk("rst_to", int'(mdu_timeout), 0);
        chk("rst_bubble", int'(idex_bubble), 1);
        idle(3);

        // Saturation of the frozen-PC counter.
        for (int j = 0; j < 10; j++) begin
            step(1, 0, 0, 0, 0, 0, 0, 1, 0);
            idle(TMO);
        end
        #2;
        chk("cnt_saturate", int'(stall_cnt), CMAX);

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 249) != 0),
                 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), 5'($urandom_range(0, 3)),
                 ($urandom_range(0, 1) == 1), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0));
        end

        @(negedge clk_i);
        #3;
        chk("queue_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
